// File: rtl/alu_issue_arbiter_if.sv
// Issue-side bundle for the shared ALU arbiter: two request slots, the ALU
// issue/result path and the writeback port.
interface alu_issue_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5,
    parameter int TAG_W  = 4
);
    logic              req0_valid, req0_ready;
    logic [OP_W-1:0]   req0_op;
    logic [DATA_W-1:0] req0_a, req0_b;
    logic [TAG_W-1:0]  req0_tag;

    logic              req1_valid, req1_ready;
    logic [OP_W-1:0]   req1_op;
    logic [DATA_W-1:0] req1_a, req1_b;
    logic [TAG_W-1:0]  req1_tag;

    logic              alu_valid;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [DATA_W-1:0] alu_res;

    logic              wb_valid, wb_src, wb_z, wb_n;
    logic [TAG_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_result;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_tag,
        output req1_valid, req1_op, req1_a, req1_b, req1_tag,
        input  req0_ready, req1_ready,
        input  alu_valid, alu_op, alu_a, alu_b,
        output alu_res,
        input  wb_valid, wb_src, wb_z, wb_n, wb_tag, wb_result
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
        input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
        output req0_ready, req1_ready,
        output alu_valid, alu_op, alu_a, alu_b,
        input  alu_res,
        output wb_valid, wb_src, wb_z, wb_n, wb_tag, wb_result
    );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter sharing one ALU between two issue slots; tags ride a
// pipeline matched to the ALU latency and rejoin the result at writeback.
module alu_issue_arbiter #(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 5,
    parameter int TAG_W   = 4,
    parameter int ALU_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               issue_en,
    input  logic               flush,
    alu_issue_arbiter_if.slave bus,
    output logic [3:0]         inflight,
    output logic [15:0]        issue_count
);
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [TAG_W-1:0]  tag;
    } req_t;

    typedef struct packed {
        logic             src;
        logic [TAG_W-1:0] tag;
    } meta_t;

    req_t              req0, req1, sel;
    logic              rr_ptr, can_grant, gnt0, gnt1, hs, cap;
    logic [ALU_LAT:0]  vld_pipe;
    meta_t             meta_pipe [ALU_LAT+1];
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              wb_valid_q, wb_src_q, wb_z_q, wb_n_q;
    logic [TAG_W-1:0]  wb_tag_q;
    logic [DATA_W-1:0] wb_result_q;

    assign req0 = '{op: bus.req0_op, a: bus.req0_a, b: bus.req0_b, tag: bus.req0_tag};
    assign req1 = '{op: bus.req1_op, a: bus.req1_a, b: bus.req1_b, tag: bus.req1_tag};

    // rst_n in the grant term keeps ready low while reset is held
    assign can_grant = rst_n & issue_en & ~flush;
    assign gnt0      = can_grant & bus.req0_valid & (~bus.req1_valid | ~rr_ptr);
    assign gnt1      = can_grant & bus.req1_valid & (~bus.req0_valid |  rr_ptr);
    assign hs        = gnt0 | gnt1;
    assign sel       = gnt1 ? req1 : req0;
    assign cap       = vld_pipe[ALU_LAT] & ~flush;

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.alu_valid  = vld_pipe[0];
    assign bus.alu_op     = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_src     = wb_src_q;
    assign bus.wb_tag     = wb_tag_q;
    assign bus.wb_result  = wb_result_q;
    assign bus.wb_z       = wb_z_q;
    assign bus.wb_n       = wb_n_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= 1'b0;
            issue_count <= '0;
            inflight    <= '0;
            vld_pipe    <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            for (int k = 0; k <= ALU_LAT; k++) meta_pipe[k] <= '0;
            wb_valid_q  <= 1'b0;
            wb_src_q    <= 1'b0;
            wb_tag_q    <= '0;
            wb_result_q <= '0;
            wb_z_q      <= 1'b0;
            wb_n_q      <= 1'b0;
        end else begin
            if (hs) begin
                rr_ptr       <= gnt0;
                issue_count  <= issue_count + 16'd1;
                op_q         <= sel.op;
                a_q          <= sel.a;
                b_q          <= sel.b;
                meta_pipe[0] <= '{src: gnt1, tag: sel.tag};
            end
            for (int k = 1; k <= ALU_LAT; k++) meta_pipe[k] <= meta_pipe[k-1];

            // stage 0 is the ALU issue register; stage ALU_LAT lines up with alu_res
            vld_pipe <= flush ? '0 : {vld_pipe[ALU_LAT-1:0], hs};
            inflight <= flush ? '0 : inflight + 4'(hs) - 4'(wb_valid_q);

            wb_valid_q <= cap;
            if (cap) begin
                wb_src_q    <= meta_pipe[ALU_LAT].src;
                wb_tag_q    <= meta_pipe[ALU_LAT].tag;
                wb_result_q <= bus.alu_res;
                wb_z_q      <= (bus.alu_res == '0);
                wb_n_q      <= bus.alu_res[DATA_W-1];
            end
        end
    end
endmodule
